// File: rtl/audio_pkg.sv
// Shared widths, FSM encoding and saturation limits for the audio DC conditioner.
package audio_pkg;

  localparam int unsigned AUD_W = 16;
  localparam int unsigned ACC_W = 18;
  localparam int unsigned ADC_W = 10;

  localparam logic signed [AUD_W-1:0] AUD_MAX = {1'b0, {(AUD_W-1){1'b1}}};
  localparam logic signed [AUD_W-1:0] AUD_MIN = {1'b1, {(AUD_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFilt,
    StScale,
    StOut
  } state_e;

endpackage

// File: rtl/audio_dc_conditioner_sat_clamp.sv
// Combinational signed clamp from InW bits down to OutW bits, with a clamp flag.
module sat_clamp #(
  parameter int unsigned              InW    = 20,
  parameter int unsigned              OutW   = 18,
  parameter logic signed [OutW-1:0]   MaxVal = {1'b0, {(OutW-1){1'b1}}},
  parameter logic signed [OutW-1:0]   MinVal = {1'b1, {(OutW-1){1'b0}}}
) (
  input  logic signed [InW-1:0]  in_i,
  output logic signed [OutW-1:0] out_o,
  output logic                   sat_o
);

  localparam logic signed [InW-1:0] MaxExt = InW'(MaxVal);
  localparam logic signed [InW-1:0] MinExt = InW'(MinVal);

  always_comb begin
    out_o = in_i[OutW-1:0];
    sat_o = 1'b0;
    if (in_i > MaxExt) begin
      out_o = MaxVal;
      sat_o = 1'b1;
    end else if (in_i < MinExt) begin
      out_o = MinVal;
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/audio_dc_conditioner.sv
// Re-centres 10-bit ADC samples, removes DC with a first-order HPF, applies shift gain
// and saturates to a 16-bit signed audio sample.
module audio_dc_conditioner
  import audio_pkg::*;
#(
  parameter int unsigned HPF_SHIFT  = 6,
  parameter int unsigned GAIN_SHIFT = 0,
  parameter bit          HPF_BYPASS = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [ADC_W-1:0] i_adc_dt,
  input  logic             i_adc_dt_en,
  output logic [AUD_W-1:0] o_aud_dt,
  output logic             o_aud_en,
  output logic             o_sat,
  output logic             o_ovr
);

  // Headroom so neither the filter sum nor the gain shift can wrap before clamping.
  localparam int unsigned FiltW  = ACC_W + 2;
  localparam int unsigned ScaleW = ACC_W + 4;

  state_e                  state_q, state_d;
  logic [ADC_W-1:0]        adc_q;
  logic signed [AUD_W-1:0] x16_q, x1_q, scl_q;
  logic signed [ACC_W-1:0] y_q, y1_q;
  logic                    scl_sat_q;

  logic signed [FiltW-1:0]  filt_sum;
  logic signed [ACC_W-1:0]  filt_y;
  logic                     unused_filt_sat;
  logic signed [ScaleW-1:0] scale_in;
  logic signed [AUD_W-1:0]  scl_y;
  logic                     scl_sat;

  always_comb begin
    if (HPF_BYPASS) begin
      filt_sum = FiltW'(x16_q);
    end else begin
      filt_sum = FiltW'(x16_q) - FiltW'(x1_q) + FiltW'(y1_q) - FiltW'(y1_q >>> HPF_SHIFT);
    end
  end

  sat_clamp #(
    .InW   (FiltW),
    .OutW  (ACC_W),
    .MaxVal(ACC_MAX),
    .MinVal(ACC_MIN)
  ) u_filt_clamp (
    .in_i (filt_sum),
    .out_o(filt_y),
    .sat_o(unused_filt_sat)
  );

  assign scale_in = ScaleW'(y_q) <<< GAIN_SHIFT;

  sat_clamp #(
    .InW   (ScaleW),
    .OutW  (AUD_W),
    .MaxVal(AUD_MAX),
    .MinVal(AUD_MIN)
  ) u_scale_clamp (
    .in_i (scale_in),
    .out_o(scl_y),
    .sat_o(scl_sat)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (i_adc_dt_en) state_d = StLoad;
      StLoad:  state_d = StFilt;
      StFilt:  state_d = StScale;
      StScale: state_d = StOut;
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      adc_q     <= '0;
      x16_q     <= '0;
      x1_q      <= '0;
      y_q       <= '0;
      y1_q      <= '0;
      scl_q     <= '0;
      scl_sat_q <= 1'b0;
      o_aud_dt  <= '0;
      o_aud_en  <= 1'b0;
      o_sat     <= 1'b0;
      o_ovr     <= 1'b0;
    end else begin
      o_aud_en <= 1'b0;
      o_sat    <= 1'b0;
      if (i_adc_dt_en && (state_q != StIdle)) o_ovr <= 1'b1;
      case (state_q)
        StIdle: if (i_adc_dt_en) adc_q <= i_adc_dt;
        // Inverting the MSB turns offset binary into two's complement (d - 512).
        StLoad: x16_q <= {~adc_q[ADC_W-1], adc_q[ADC_W-2:0], {(AUD_W-ADC_W){1'b0}}};
        StFilt: begin
          y_q <= filt_y;
          if (!HPF_BYPASS) begin
            x1_q <= x16_q;
            y1_q <= filt_y;
          end
        end
        StScale: begin
          scl_q     <= scl_y;
          scl_sat_q <= scl_sat;
        end
        StOut: begin
          o_aud_dt <= scl_q;
          o_sat    <= scl_sat_q;
          o_aud_en <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
